// File: rtl/keypad_scan_ctrl.sv
// Shared scanner for a 4x4 active-low key matrix: row strobing, full-matrix
// snapshot debounce, and press/release events on a valid/ready port.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic [15:0] key_state,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_code,
  output logic        ev_release,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int MATCH_W = $clog2(STABLE_CNT);
  localparam logic [SLOT_W-1:0]  SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(STABLE_CNT - 1);

  typedef enum logic {EV_IDLE, EV_SEND} evStateT;

  evStateT             evState, evStateNext;
  logic [3:0]          colMeta, colSync;
  logic [SLOT_W-1:0]   slotCnt;
  logic [1:0]          rowIdx;
  logic [15:0]         snapshot, prevSnap, keyStateQ, fullSnap;
  logic [MATCH_W-1:0]  matchCnt, matchNext;
  logic                slotEnd, scanDone, accept;
  logic [15:0]         pendRel, pendPrs, pendAll, pickSrc, clrMask, clrRel, clrPrs;
  logic [15:0]         newRel, newPrs;
  logic [3:0]          pickCode, evCodeQ;
  logic                pickRel, load, evReleaseQ, overflowQ;

  assign slotEnd  = (slotCnt == SLOT_LAST);
  assign scanDone = slotEnd && (rowIdx == 2'd3);
  // Row 3 lands in the same cycle the full snapshot is judged.
  assign fullSnap = {~colSync, snapshot[11:0]};

  always_comb begin
    matchNext = '0;
    if (fullSnap == prevSnap)
      matchNext = (matchCnt == MATCH_MAX) ? matchCnt : matchCnt + 1'b1;
  end

  assign accept = scanDone && (matchNext == MATCH_MAX) && (fullSnap != keyStateQ);
  assign newRel = accept ? (keyStateQ & ~fullSnap) : '0;
  assign newPrs = accept ? (fullSnap & ~keyStateQ) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      colMeta   <= 4'hF;
      colSync   <= 4'hF;
      slotCnt   <= '0;
      rowIdx    <= 2'd0;
      snapshot  <= '0;
      prevSnap  <= '0;
      matchCnt  <= '0;
      keyStateQ <= '0;
    end else begin
      colMeta <= col_n;
      colSync <= colMeta;
      if (slotEnd) begin
        slotCnt                        <= '0;
        rowIdx                         <= rowIdx + 2'd1;
        snapshot[{rowIdx, 2'b00} +: 4] <= ~colSync;
      end else begin
        slotCnt <= slotCnt + 1'b1;
      end
      if (scanDone) begin
        matchCnt <= matchNext;
        prevSnap <= fullSnap;
      end
      if (accept)
        keyStateQ <= fullSnap;
    end
  end

  // Releases drain before presses; lowest index wins within a class.
  always_comb begin
    pendAll  = pendRel | pendPrs;
    pickRel  = (pendRel != '0);
    pickSrc  = pickRel ? pendRel : pendPrs;
    pickCode = '0;
    for (int i = 15; i >= 0; i--)
      if (pickSrc[i]) pickCode = 4'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) evState <= EV_IDLE;
    else     evState <= evStateNext;
  end

  always_comb begin
    evStateNext = evState;
    load        = 1'b0;
    case (evState)
      EV_IDLE:
        if (pendAll != '0) begin
          load        = 1'b1;
          evStateNext = EV_SEND;
        end
      EV_SEND:
        if (ev_ready) begin
          if (pendAll != '0) load = 1'b1;
          else               evStateNext = EV_IDLE;
        end
      default: evStateNext = EV_IDLE;
    endcase
    clrMask = 16'b1 << pickCode;
    clrRel  = (load && pickRel)  ? clrMask : '0;
    clrPrs  = (load && !pickRel) ? clrMask : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendRel    <= '0;
      pendPrs    <= '0;
      evCodeQ    <= '0;
      evReleaseQ <= 1'b0;
      overflowQ  <= 1'b0;
    end else begin
      pendRel <= (pendRel & ~clrRel) | newRel;
      pendPrs <= (pendPrs & ~clrPrs) | newPrs;
      if (load) begin
        evCodeQ    <= pickCode;
        evReleaseQ <= pickRel;
      end
      // An undelivered event still on the port counts as pending work.
      if (accept && ((pendAll != '0) || ev_valid)) overflowQ <= 1'b1;
      else if (clr_overflow)                       overflowQ <= 1'b0;
    end
  end

  assign row_n      = ~(4'b0001 << rowIdx);
  assign key_state  = keyStateQ;
  assign ev_valid   = (evState == EV_SEND);
  assign ev_code    = evCodeQ;
  assign ev_release = evReleaseQ;
  assign overflow   = overflowQ;

endmodule
